// File: rtl/cell_check_initiator_if.sv
// Game-control and board-RAM signal bundle of the cell-check initiator.
interface cell_check_initiator_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              newGame;
    logic              click;
    logic [2:0]        clickRow;
    logic [2:0]        clickCol;
    logic              busy;
    logic              nowCheck;
    logic [DATA_W-1:0] checkID;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdData;
    logic              revealWe;
    logic [ADDR_W-1:0] revealAddr;
    logic              done;
    logic              hitMine;
    logic              badCoord;
    logic [7:0]        revealCount;

    modport master (
        input  newGame, click, clickRow, clickCol, rdData,
        output busy, nowCheck, checkID, rdAddr, revealWe, revealAddr,
               done, hitMine, badCoord, revealCount
    );

    modport slave (
        output newGame, click, clickRow, clickCol, rdData,
        input  busy, nowCheck, checkID, rdAddr, revealWe, revealAddr,
               done, hitMine, badCoord, revealCount
    );
endinterface

// File: rtl/cell_check_initiator.sv
// Minesweeper cell-check initiator: click -> check strobe, board read, reveal.
// Define FLOOD_FILL_EN to build the zero-cell flood fill (neighbour scan + LIFO).
module cell_check_initiator #(
    parameter int unsigned ROWS   = 5,
    parameter int unsigned COLS   = 5,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    cell_check_initiator_if.master bus
);
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned ID_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, FETCH, EVAL, NEIGH, POP, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]       cur_row, cur_col;
    logic [ID_W-1:0]  cur_id, click_id;
    logic [CELLS-1:0] revealed;
    logic [LAT_W-1:0] lat_cnt;
    logic             click_bad;
    logic             accept, clear_maps, do_reveal, set_hit;
    logic             unused_bits;

    assign cur_id    = ID_W'(int'(cur_row) * int'(COLS) + int'(cur_col));
    assign click_id  = ID_W'(int'(bus.clickRow) * int'(COLS) + int'(bus.clickCol));
    assign click_bad = (32'(bus.clickRow) >= ROWS) || (32'(bus.clickCol) >= COLS);

`ifdef FLOOD_FILL_EN
    localparam int unsigned SP_W = $clog2(CELLS + 1);
    logic [CELLS-1:0] queued;
    logic [2:0]       stk_row [CELLS];
    logic [2:0]       stk_col [CELLS];
    logic [SP_W-1:0]  sp;
    logic [2:0]       nb_idx, nb_row, nb_col, top_row, top_col;
    logic [ID_W-1:0]  nb_id, top_id;
    logic             nb_ok, push, pop;
    int               dr, dc, nr, nc;

    assign top_row = stk_row[sp - 1'b1];
    assign top_col = stk_col[sp - 1'b1];
    assign top_id  = ID_W'(int'(top_row) * int'(COLS) + int'(top_col));
    assign unused_bits = ^bus.rdData[DATA_W-1:5];

    // Current neighbour of the scan and whether it still needs a visit.
    always_comb begin
        dr = 0;
        dc = 0;
        case (nb_idx)
            3'd0: begin dr = -1; dc = -1; end
            3'd1: begin dr = -1; dc =  0; end
            3'd2: begin dr = -1; dc =  1; end
            3'd3: begin dr =  0; dc = -1; end
            3'd4: begin dr =  0; dc =  1; end
            3'd5: begin dr =  1; dc = -1; end
            3'd6: begin dr =  1; dc =  0; end
            default: begin dr = 1; dc = 1; end
        endcase
        nr     = int'(cur_row) + dr;
        nc     = int'(cur_col) + dc;
        nb_row = 3'(nr);
        nb_col = 3'(nc);
        nb_id  = '0;
        nb_ok  = 1'b0;
        if (nr >= 0 && nr < int'(ROWS) && nc >= 0 && nc < int'(COLS)) begin
            nb_id = ID_W'(nr * int'(COLS) + nc);
            nb_ok = !revealed[nb_id] && !queued[nb_id];
        end
    end
`else
    assign unused_bits = ^bus.rdData[DATA_W-1:1];
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        clear_maps = 1'b0;
        do_reveal  = 1'b0;
        set_hit    = 1'b0;
`ifdef FLOOD_FILL_EN
        push       = 1'b0;
        pop        = 1'b0;
`endif
        case (state)
            IDLE: begin
                clear_maps = bus.newGame;
                if (bus.click) begin
                    accept    = 1'b1;
                    state_nxt = click_bad ? DONE : CHECK;
                end
            end
            CHECK: state_nxt = FETCH;
            FETCH: if (lat_cnt == LAT_W'(RD_LAT - 1)) state_nxt = EVAL;
            EVAL: begin
                if (revealed[cur_id]) begin
                    state_nxt = POP;
                end else begin
                    do_reveal = 1'b1;
                    if (bus.rdData[0]) begin
                        set_hit   = 1'b1;
                        state_nxt = DONE;
                    end else begin
`ifdef FLOOD_FILL_EN
                        state_nxt = (bus.rdData[4:1] == 4'd0) ? NEIGH : POP;
`else
                        state_nxt = POP;
`endif
                    end
                end
            end
`ifdef FLOOD_FILL_EN
            NEIGH: begin
                push = nb_ok;
                if (nb_idx == 3'd7) state_nxt = POP;
            end
            POP: begin
                if (sp == '0) begin
                    state_nxt = DONE;
                end else begin
                    pop       = 1'b1;
                    state_nxt = FETCH;
                end
            end
`else
            POP: state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, bitmaps and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_row         <= '0;
            cur_col         <= '0;
            revealed        <= '0;
            lat_cnt         <= '0;
            bus.busy        <= 1'b0;
            bus.nowCheck    <= 1'b0;
            bus.checkID     <= '0;
            bus.rdAddr      <= '0;
            bus.revealWe    <= 1'b0;
            bus.revealAddr  <= '0;
            bus.done        <= 1'b0;
            bus.hitMine     <= 1'b0;
            bus.badCoord    <= 1'b0;
            bus.revealCount <= '0;
        end else begin
            if (clear_maps) revealed <= '0;
            if (do_reveal)  revealed[cur_id] <= 1'b1;
            lat_cnt <= (state == FETCH) ? lat_cnt + 1'b1 : '0;

            bus.busy     <= (state_nxt != IDLE);
            bus.nowCheck <= (state_nxt == CHECK);
            bus.done     <= (state_nxt == DONE);
            bus.checkID  <= '0;
            bus.revealWe <= do_reveal;

            if (accept && !click_bad) begin
                cur_row     <= bus.clickRow;
                cur_col     <= bus.clickCol;
                bus.checkID <= DATA_W'(click_id);
                bus.rdAddr  <= ADDR_W'(click_id);
            end
`ifdef FLOOD_FILL_EN
            if (pop) begin
                cur_row    <= top_row;
                cur_col    <= top_col;
                bus.rdAddr <= ADDR_W'(top_id);
            end
`endif
            if (do_reveal) begin
                bus.revealAddr <= ADDR_W'(cur_id);
                if (bus.revealCount != 8'hFF) bus.revealCount <= bus.revealCount + 8'd1;
            end
            if (accept) begin
                bus.hitMine     <= 1'b0;
                bus.badCoord    <= click_bad;
                bus.revealCount <= '0;
            end
            if (set_hit) bus.hitMine <= 1'b1;
        end
    end

`ifdef FLOOD_FILL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            queued <= '0;
            sp     <= '0;
            nb_idx <= '0;
        end else begin
            if (clear_maps) queued <= '0;
            nb_idx <= (state == NEIGH) ? nb_idx + 3'd1 : 3'd0;
            if (push) begin
                queued[nb_id] <= 1'b1;
                sp            <= sp + 1'b1;
            end
            if (pop) begin
                queued[top_id] <= 1'b0;
                sp             <= sp - 1'b1;
            end
        end
    end

    // Stack storage needs no reset; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            stk_row[sp] <= nb_row;
            stk_col[sp] <= nb_col;
        end
    end
`endif
endmodule

// File: doc/cell_check_initiator.md
Name: cell_check_initiator

Overview:
- Initiator side of the board RAM cell-check interface for the Minesweeper game.
- Turns a player click at (row, col) into a one-cycle nowCheck/checkID request and reads the cell word back through the board read port.
- Reveals cells, flood-filling from zero-count cells, and reports mine hit and reveal count to game control.
- Sits between the input/cursor logic and the board BlockRAM.

Parameters:
ROWS, 5, board rows
COLS, 5, board columns
ADDR_W, 12, board memory address width
DATA_W, 32, board word width and checkID width
RD_LAT, 1, board read latency in cycles (>=1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
newGame  input  1  pulse; clears revealed/queued bitmaps (ignored while busy)
click  input  1  pulse; request check of (clickRow, clickCol)
clickRow  input  3  row index
clickCol  input  3  column index
busy  output  1  high from click accept until done
nowCheck  output  1  one-cycle check strobe to board RAM
checkID  output  DATA_W  cell id = row*COLS+col, valid with nowCheck
rdAddr  output  ADDR_W  board read address
rdData  input  DATA_W  board word; bit0 = mine, bits[4:1] = neighbour count
revealWe  output  1  one-cycle reveal write strobe
revealAddr  output  ADDR_W  cell id being revealed
done  output  1  one-cycle completion pulse
hitMine  output  1  clicked cell was a mine; held until next accept
badCoord  output  1  last click was out of range; held until next accept
revealCount  output  8  cells newly revealed by last click; held until next accept

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, and the revealed, queued and stack state is cleared. Reset mid-operation aborts immediately; outputs read 0 the following cycle.
- Cell id = row*COLS+col, zero-extended to the port width.
- IDLE:
  - click=1 (busy=0) clears hitMine, badCoord and revealCount.
  - Row >= ROWS or col >= COLS: set badCoord, go to DONE; no nowCheck is issued.
  - Otherwise latch the id into cur and go to CHECK.
  - newGame in IDLE clears the bitmaps. newGame and click in the same cycle: clear first, then accept.
  - click while busy is ignored, not queued.
- CHECK (1 cycle): nowCheck=1, checkID=id; go to FETCH.
- FETCH (RD_LAT cycles): rdAddr=cur, held; go to EVAL.
- EVAL (1 cycle): sample rdData.
  - cur already revealed: go to POP.
  - Otherwise: mark revealed, pulse revealWe with revealAddr=cur, revealCount+1 (saturates at 255).
  - mine=1: only possible for the clicked cell. Set hitMine and go to DONE with no flood.
  - count==0: go to NEIGH.
  - Else: go to POP.
- NEIGH (8 cycles): visit offsets (-1,-1),(-1,0),(-1,1),(0,-1),(0,1),(1,-1),(1,0),(1,1), one per cycle. Push the neighbour onto the LIFO stack only if it is in range, not revealed and not queued; set its queued bit. Then go to POP.
- POP (1 cycle):
  - Stack empty: go to DONE.
  - Else: cur = pop, clear its queued bit, go to FETCH.
  - Stack depth is ROWS*COLS; the queued bitmap guarantees no overflow.
- DONE (1 cycle): done=1, go to IDLE. busy=0 only in IDLE.
- Latency, click sampled at edge 0:
  - Safe non-zero cell: done in cycle 4+RD_LAT.
  - Mine: done in cycle 3+RD_LAT.
  - Bad coordinate: done in cycle 1.
- Clicking an already revealed cell: one nowCheck, no revealWe, revealCount=0.

Optional Feature:
- FLOOD_FILL_EN defined: NEIGH state, stack and queued bitmap are present; behaviour as above.
- Not defined: EVAL always goes to POP for a safe cell (never NEIGH), and POP always finds the stack empty. Only the clicked cell is revealed, revealCount <= 1, and the stack logic is not synthesised.

Test Plan:
- Reset held 2 cycles -> all outputs 0, busy=0.
- Mine only at id 0; click (0,1), RD_LAT=1 -> nowCheck for 1 cycle with checkID=1; revealWe once, addr 1; done in cycle 5; revealCount=1, hitMine=0.
- Click (0,0) -> hitMine=1, revealCount=1, done in cycle 4, no other revealWe.
- New game, mine only at 0; click (4,4) with FLOOD_FILL_EN -> 24 revealWe, each id 1..24 exactly once, never 0; revealCount=24; without the macro revealCount=1.
- Re-click (4,4) -> revealCount=0, no revealWe. Then newGame and click (4,4) -> revealCount=24 again.
- Click (5,2) -> badCoord=1, done in cycle 1, nowCheck never asserted. A click while busy is ignored. reset asserted mid-flood -> busy=0 and all outputs 0 the next cycle.
